// File: rtl/vga_text_writer.sv
// Character-stream front end for the text-mode frame buffer: glyph fetch,
// cursor tracking, control codes and full-screen clear.
module vga_text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic         clr,
  output logic [6:0]   font_addr,
  input  logic [127:0] font_data,
  output logic         wr,
  output logic [127:0] w_data,
  output logic [6:0]   w_col,
  output logic [4:0]   w_row,
  output logic         busy,
  output logic [6:0]   cur_col,
  output logic [4:0]   cur_row
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic [127:0]   w_data_q, w_data_d;
  logic [6:0]     w_col_q, w_col_d;
  logic [4:0]     w_row_q, w_row_d;
  logic [6:0]     font_addr_q, font_addr_d;
  logic [6:0]     cur_col_q, cur_col_d;
  logic [4:0]     cur_row_q, cur_row_d;
  logic           accept_s;
  logic           printable_s;
  logic [6:0]     adv_col_s;
  logic [4:0]     adv_row_s;
  logic [4:0]     next_row_s;

  assign in_ready    = (state_q == S_IDLE) && !clr && !rst;
  assign accept_s    = in_valid && in_ready;
  assign printable_s = (in_data >= 8'h20) && (in_data <= 8'h7E);

  assign font_addr = font_addr_q;
  assign wr        = wr_q;
  assign w_data    = w_data_q;
  assign w_col     = w_col_q;
  assign w_row     = w_row_q;
  assign cur_col   = cur_col_q;
  assign cur_row   = cur_row_q;
  assign busy      = (state_q != S_IDLE);

  // Cursor successor: one step right, wrapping to the next row and then to row 0.
  always_comb begin
    next_row_s = (cur_row_q == ROW_MAX) ? 5'd0 : cur_row_q + 5'd1;
    if (cur_col_q == COL_MAX) begin
      adv_col_s = 7'd0;
      adv_row_s = next_row_s;
    end else begin
      adv_col_s = cur_col_q + 7'd1;
      adv_row_s = cur_row_q;
    end
  end

  // Next-state and next-output logic for the writer FSM.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    w_data_d    = w_data_q;
    w_col_d     = w_col_q;
    w_row_d     = w_row_q;
    font_addr_d = font_addr_q;
    cur_col_d   = cur_col_q;
    cur_row_d   = cur_row_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d  = S_CLEAR;
          wr_d     = 1'b1;
          w_data_d = 128'd0;
          w_col_d  = 7'd0;
          w_row_d  = 5'd0;
        end else if (accept_s) begin
          if (printable_s) begin
            state_d     = S_FETCH;
            font_addr_d = in_data[6:0];
          end else begin
            case (in_data)
              8'h0D: cur_col_d = 7'd0;
              8'h0A: begin
                cur_col_d = 7'd0;
                cur_row_d = next_row_s;
              end
              8'h08: begin
                if (cur_col_q != 7'd0) begin
                  cur_col_d = cur_col_q - 7'd1;
                end else if (cur_row_q != 5'd0) begin
                  cur_col_d = COL_MAX;
                  cur_row_d = cur_row_q - 5'd1;
                end else begin
                  cur_col_d = cur_col_q;
                end
              end
              default: cur_col_d = cur_col_q;
            endcase
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_WAIT;
      // ROM output is valid now; capture it together with the write position.
      S_WAIT: begin
        state_d   = S_WRITE;
        wr_d      = 1'b1;
        w_data_d  = font_data;
        w_col_d   = cur_col_q;
        w_row_d   = cur_row_q;
        cur_col_d = adv_col_s;
        cur_row_d = adv_row_s;
      end
      S_WRITE: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
      end
      S_CLEAR: begin
        if ((w_col_q == COL_MAX) && (w_row_q == ROW_MAX)) begin
          state_d   = S_IDLE;
          wr_d      = 1'b0;
          cur_col_d = 7'd0;
          cur_row_d = 5'd0;
        end else if (w_col_q == COL_MAX) begin
          w_col_d = 7'd0;
          w_row_d = w_row_q + 5'd1;
        end else begin
          w_col_d = w_col_q + 7'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      w_data_q    <= 128'd0;
      w_col_q     <= 7'd0;
      w_row_q     <= 5'd0;
      font_addr_q <= 7'd0;
      cur_col_q   <= 7'd0;
      cur_row_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      w_data_q    <= w_data_d;
      w_col_q     <= w_col_d;
      w_row_q     <= w_row_d;
      font_addr_q <= font_addr_d;
      cur_col_q   <= cur_col_d;
      cur_row_q   <= cur_row_d;
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer with a synchronous font ROM model.
module tb_vga_text_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         clr;
  logic [6:0]   font_addr;
  logic [127:0] font_data;
  logic         wr;
  logic [127:0] w_data;
  logic [6:0]   w_col;
  logic [4:0]   w_row;
  logic         busy;
  logic [6:0]   cur_col;
  logic [4:0]   cur_row;

  int total = 0;
  int bad   = 0;

  vga_text_writer #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr(clr), .font_addr(font_addr),
    .font_data(font_data), .wr(wr), .w_data(w_data), .w_col(w_col),
    .w_row(w_row), .busy(busy), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  // Glyph k: each 16-bit pair is {~code, code}.
  function automatic logic [127:0] rom(input logic [6:0] a);
    logic [7:0] b;
    b = {1'b0, a};
    return {8{~b, b}};
  endfunction

  always @(posedge clk) font_data <= rom(font_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) repeat (3) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    total++;
    if ({wr, w_data, w_col, w_row, font_addr, cur_col, cur_row, busy} !== 155'd0) begin
      bad++; $display("FAIL reset_outputs wr=%b col=%0d row=%0d fa=%h cur=(%0d,%0d) busy=%b want all 0",
                      wr, w_col, w_row, font_addr, cur_col, cur_row, busy);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL ready_in_reset got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", in_ready); end
  endtask

  task automatic test_glyph();
    in_valid = 1'b1; in_data = 8'h41;
    step();
    in_valid = 1'b0;
    total++;
    if ({font_addr, wr, busy, in_ready} !== {7'h41, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL glyph_c1 fa=%h wr=%b busy=%b rdy=%b want 41 0 1 0", font_addr, wr, busy, in_ready);
    end
    step();
    total++;
    if (wr !== 1'b0) begin bad++; $display("FAIL glyph_c2_wr got=%b want=0", wr); end
    step();
    total++;
    if ({wr, w_col, w_row} !== {1'b1, 7'd0, 5'd0}) begin
      bad++; $display("FAIL glyph_c3_pos wr=%b col=%0d row=%0d want 1 0 0", wr, w_col, w_row);
    end
    total++;
    if (w_data !== 128'hBE41BE41BE41BE41BE41BE41BE41BE41) begin
      bad++; $display("FAIL glyph_c3_data got=%h want=BE41x8", w_data);
    end
    total++;
    if ({cur_col, cur_row} !== {7'd1, 5'd0}) begin
      bad++; $display("FAIL glyph_cursor got=(%0d,%0d) want=(1,0)", cur_col, cur_row);
    end
    step();
    total++;
    if ({wr, in_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL glyph_c4 wr=%b rdy=%b busy=%b want 0 1 0", wr, in_ready, busy);
    end
    total++;
    if (w_data !== 128'hBE41BE41BE41BE41BE41BE41BE41BE41) begin
      bad++; $display("FAIL glyph_hold got=%h want=BE41x8", w_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; in_data = 8'h48;
    step();
    in_data = 8'h49;
    step(); step();
    total++;
    if ({wr, w_col, w_data} !== {1'b1, 7'd0, 128'hB748B748B748B748B748B748B748B748}) begin
      bad++; $display("FAIL b2b_first wr=%b col=%0d data=%h want 1 0 B748x8", wr, w_col, w_data);
    end
    step();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready); end
    step();
    in_valid = 1'b0;
    step(); step();
    total++;
    if ({wr, w_col, w_data} !== {1'b1, 7'd1, 128'hB649B649B649B649B649B649B649B649}) begin
      bad++; $display("FAIL b2b_second wr=%b col=%0d data=%h want 1 1 B649x8", wr, w_col, w_data);
    end
    step();
  endtask

  task automatic test_control();
    do_reset();
    repeat (3) put(8'h0A);
    repeat (5) put(8'h20);
    total++;
    if ({cur_col, cur_row} !== {7'd5, 5'd3}) begin
      bad++; $display("FAIL ctl_setup got=(%0d,%0d) want=(5,3)", cur_col, cur_row);
    end
    put(8'h0D);
    total++;
    if ({cur_col, cur_row, wr, busy} !== {7'd0, 5'd3, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ctl_cr got=(%0d,%0d) wr=%b busy=%b want=(0,3) 0 0", cur_col, cur_row, wr, busy);
    end
    put(8'h0A);
    total++;
    if ({cur_col, cur_row} !== {7'd0, 5'd4}) begin
      bad++; $display("FAIL ctl_lf got=(%0d,%0d) want=(0,4)", cur_col, cur_row);
    end
    put(8'h08);
    total++;
    if ({cur_col, cur_row} !== {7'd79, 5'd3}) begin
      bad++; $display("FAIL ctl_bs_wrap got=(%0d,%0d) want=(79,3)", cur_col, cur_row);
    end
    put(8'h08);
    total++;
    if ({cur_col, cur_row} !== {7'd78, 5'd3}) begin
      bad++; $display("FAIL ctl_bs got=(%0d,%0d) want=(78,3)", cur_col, cur_row);
    end
    do_reset();
    put(8'h08);
    total++;
    if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
      bad++; $display("FAIL ctl_bs_origin got=(%0d,%0d) want=(0,0)", cur_col, cur_row);
    end
    put(8'h20);
    put(8'h07);
    total++;
    if ({cur_col, cur_row, wr, in_ready, busy} !== {7'd1, 5'd0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ctl_bel got=(%0d,%0d) wr=%b rdy=%b busy=%b want=(1,0) 0 1 0",
                      cur_col, cur_row, wr, in_ready, busy);
    end
    put(8'hFF);
    total++;
    if ({cur_col, cur_row, wr} !== {7'd1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL ctl_ff got=(%0d,%0d) wr=%b want=(1,0) 0", cur_col, cur_row, wr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (29) put(8'h0A);
    repeat (79) put(8'h2E);
    total++;
    if ({cur_col, cur_row} !== {7'd79, 5'd29}) begin
      bad++; $display("FAIL wrap_setup got=(%0d,%0d) want=(79,29)", cur_col, cur_row);
    end
    in_valid = 1'b1; in_data = 8'h42;
    step();
    in_valid = 1'b0;
    step(); step();
    total++;
    if ({wr, w_col, w_row, w_data} !== {1'b1, 7'd79, 5'd29, 128'hBD42BD42BD42BD42BD42BD42BD42BD42}) begin
      bad++; $display("FAIL wrap_write wr=%b col=%0d row=%0d data=%h want 1 79 29 BD42x8", wr, w_col, w_row, w_data);
    end
    total++;
    if ({cur_col, cur_row} !== {7'd0, 5'd0}) begin
      bad++; $display("FAIL wrap_cursor got=(%0d,%0d) want=(0,0)", cur_col, cur_row);
    end
    step();
  endtask

  task automatic test_clear();
    do_reset();
    put(8'h41);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h43;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_blocks_ready got=%b want=0", in_ready); end
    for (int i = 0; i < 2400; i++) begin
      step();
      clr = 1'b0;
      total++;
      if ({wr, w_data, w_col, w_row, in_ready, busy} !== {1'b1, 128'd0, 7'(i % 80), 5'(i / 80), 1'b0, 1'b1}) begin
        bad++; $display("FAIL clr_cell i=%0d wr=%b data0=%b col=%0d row=%0d rdy=%b busy=%b want 1 1 %0d %0d 0 1",
                        i, wr, (w_data == 128'd0), w_col, w_row, in_ready, busy, i % 80, i / 80);
      end
    end
    step();
    total++;
    if ({wr, cur_col, cur_row, busy, in_ready} !== {1'b0, 7'd0, 5'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL clr_done wr=%b cur=(%0d,%0d) busy=%b rdy=%b want 0 (0,0) 0 1",
                      wr, cur_col, cur_row, busy, in_ready);
    end
    step();
    in_valid = 1'b0;
    total++;
    if ({busy, font_addr} !== {1'b1, 7'h43}) begin
      bad++; $display("FAIL clr_held_byte busy=%b fa=%h want 1 43", busy, font_addr);
    end
    step(); step();
    total++;
    if ({wr, w_col, w_row, w_data} !== {1'b1, 7'd0, 5'd0, 128'hBC43BC43BC43BC43BC43BC43BC43BC43}) begin
      bad++; $display("FAIL clr_after_write wr=%b col=%0d row=%0d data=%h want 1 0 0 BC43x8", wr, w_col, w_row, w_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int extra;
    do_reset();
    put(8'h20); put(8'h20);
    in_valid = 1'b1; in_data = 8'h41;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({wr, cur_col, cur_row, busy} !== {1'b0, 7'd0, 5'd0, 1'b0}) begin
      bad++; $display("FAIL rst_glyph wr=%b cur=(%0d,%0d) busy=%b want 0 (0,0) 0", wr, cur_col, cur_row, busy);
    end
    extra = 0;
    repeat (10) begin step(); if (wr !== 1'b0) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL rst_glyph_quiet writes=%0d want=0", extra); end

    put(8'h20);
    clr = 1'b1;
    for (int i = 0; i <= 1000; i++) begin
      step();
      clr = 1'b0;
    end
    total++;
    if ({wr, w_col, w_row} !== {1'b1, 7'd40, 5'd12}) begin
      bad++; $display("FAIL rst_clr_cell wr=%b col=%0d row=%0d want 1 40 12", wr, w_col, w_row);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({wr, cur_col, cur_row, busy} !== {1'b0, 7'd0, 5'd0, 1'b0}) begin
      bad++; $display("FAIL rst_clear wr=%b cur=(%0d,%0d) busy=%b want 0 (0,0) 0", wr, cur_col, cur_row, busy);
    end
    extra = 0;
    repeat (20) begin step(); if (wr !== 1'b0 || busy !== 1'b0) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL rst_clear_quiet cycles=%0d want=0", extra); end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_back_to_back();
    test_control();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
Character-stream front end for the text-mode frame buffer. It accepts one byte per valid/ready handshake, interprets control codes, fetches the 8x16 glyph for printable codes from an external synchronous font ROM, and issues one 128-bit cell write on the frame-buffer write port (wr/w_data/w_col/w_row) at the cursor position. It also tracks the cursor and supports a full-screen clear. It sits directly upstream of the frame-buffer RAM write port.

Parameters:
COLS, 80, character columns per row (cursor column range 0..COLS-1)
ROWS, 30, character rows (cursor row range 0..ROWS-1)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  byte on in_data is offered
in_data  input  8  character code
in_ready  output  1  block can accept a byte this cycle
clr  input  1  clear-screen request
font_addr  output  7  glyph index to font ROM (ROM has 1-cycle read latency)
font_data  input  128  glyph from ROM; byte k = pixel row k, bit 0 = leftmost pixel
wr  output  1  frame-buffer cell write strobe
w_data  output  128  glyph written to the cell
w_col  output  7  cell column 0..79
w_row  output  5  cell row 0..29
busy  output  1  high in any state other than IDLE
cur_col  output  7  current cursor column
cur_row  output  5  current cursor row

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; wr=0; w_data=0; w_col=0; w_row=0; font_addr=0; cur_col=0; cur_row=0; busy=0.
- in_ready = (state==IDLE) && !clr && !rst. It is combinational.
- A byte is accepted when in_valid && in_ready. Call the accept cycle cycle 0.
- States:
  - IDLE -> FETCH on accepting a printable byte.
  - IDLE -> CLEAR when clr=1.
  - FETCH -> WAIT -> WRITE -> IDLE.
  - CLEAR -> IDLE after its last cell.
- Printable bytes (0x20..0x7E):
  - font_addr <= in_data[6:0] at the end of cycle 0; it stays stable in cycle 1.
  - font_data is valid in cycle 2 and is registered at the end of cycle 2 into w_data.
  - In the same edge: w_col <= cur_col, w_row <= cur_row, wr <= 1, and the cursor advances.
  - wr is 1 during cycle 3 only. in_ready is 1 again in cycle 4. Throughput is one glyph per 4 cycles.
- Cursor advance: cur_col+1. At cur_col==COLS-1: cur_col=0 and cur_row+1. Row wraps from ROWS-1 to 0. There is no scrolling.
- Control codes take effect in one cycle: accepted in cycle 0, cursor updated at the end of cycle 0, state stays IDLE, no write.
  - 0x0D (CR): cur_col=0.
  - 0x0A (LF): cur_col=0, row+1, wrapping ROWS-1 -> 0.
  - 0x08 (BS): if col>0, col-1; else if row>0, col=COLS-1 and row-1; at (0,0), no change. BS does not erase.
- All other codes (0x00..0x1F other than the above, and 0x7F..0xFF) are consumed with no effect.
- Clear:
  - clr is sampled only in IDLE; clr wins over in_valid in the same cycle. clr in any other state is ignored.
  - CLEAR writes w_data=0 to every cell in row-major order: (0,0),(1,0)..(79,0),(0,1)..(79,29).
  - wr is high for exactly COLS*ROWS = 2400 consecutive cycles, starting the cycle after clr is sampled.
  - After the last write: cursor = (0,0), wr=0, state IDLE.
- Outputs are stable between writes: w_data/w_col/w_row hold their last values while wr=0.
- Reset mid-operation: any state is abandoned at the reset edge. wr=0 from the next cycle, cursor = (0,0). An interrupted clear is not resumed, and a pending glyph is dropped.
- Widths: cursor arithmetic is done in the cursor widths. Compare against COLS-1 and ROWS-1 explicitly; do not rely on natural overflow.

Test Plan:
- Reset -> all outputs 0. in_ready=1 in the first cycle with rst=0 and clr=0. busy=0.
- Cursor (0,0), send 0x41 -> font_addr=0x41 in cycle 1; wr=1 in cycle 3 only with w_col=0, w_row=0, w_data=ROM[0x41]; cursor (1,0); in_ready=1 in cycle 4.
- Cursor (79,29), send 0x42 -> write at w_col=79, w_row=29; cursor becomes (0,0).
- Control codes:
  - At (5,3): send 0x0D -> (0,3); then 0x0A -> (0,4); then 0x08 -> (79,3).
  - At (0,0): 0x08 -> stays (0,0).
  - 0x07 -> consumed, no wr, cursor unchanged, in_ready next cycle.
- clr=1 with in_valid=1 in the same cycle -> in_ready=0 and the byte is not taken. Then 2400 consecutive wr cycles with w_data=0: first write (0,0), (79,0) followed by (0,1), last write (79,29). Cursor (0,0) afterwards, then the held byte is accepted.
- Reset asserted in cycle 2 of a glyph write, and separately at clear cell 1000 -> wr=0 next cycle, cursor (0,0), state IDLE, no further writes.
